// File: rtl/am_envelope_decimator.sv
// am_envelope_decimator
// Boxcar (integrate-and-dump) envelope detector for the AM mixer product.
// Sums DECIM unsigned samples, emits their average as one envelope sample,
// and holds it in a one-entry output register with valid/ready handshakes.
// Optional build macro AM_ENV_DC_REMOVE_EN: subtracts a slow IIR estimate of
// the carrier DC level and saturates the result to signed OUT_W.
module am_envelope_decimator #(
  parameter int IN_W     = 16,
  parameter int OUT_W    = 8,
  parameter int DECIM    = 16,
  parameter int DC_SHIFT = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic [15:0]      block_count
);

  localparam int LOG2_D = $clog2(DECIM);
  localparam int ACC_W  = IN_W + LOG2_D;
  localparam logic [LOG2_D-1:0] CNT_LAST = LOG2_D'(DECIM - 1);

  logic [ACC_W-1:0]  acc;
  logic [ACC_W-1:0]  sum;
  logic [LOG2_D-1:0] cnt;
  logic [IN_W-1:0]   avg;
  logic [OUT_W-1:0]  env;
  logic              last_slot;
  logic              in_xfer;
  logic              out_xfer;
  logic              closing;

  // Only the block-closing sample can be stalled by a full output register.
  assign last_slot = (cnt == CNT_LAST);
  assign in_ready  = !(out_valid && !out_ready && last_slot);
  assign in_xfer   = in_valid && in_ready;
  assign out_xfer  = out_valid && out_ready;
  assign closing   = in_xfer && last_slot;

  // Block sum including the current sample; DECIM is a power of two so the
  // average is just the top IN_W bits of the sum.
  assign sum = acc + ACC_W'(in_data);
  assign avg = sum[ACC_W-1:LOG2_D];

`ifdef AM_ENV_DC_REMOVE_EN
  localparam int DC_W = IN_W + DC_SHIFT + 1;
  localparam int Y_W  = IN_W + 2;
  localparam logic signed [Y_W-1:0] SAT_MAX = Y_W'((64'sd1 <<< (OUT_W - 1)) - 64'sd1);
  localparam logic signed [Y_W-1:0] SAT_MIN = -SAT_MAX - Y_W'(1);

  logic signed [DC_W-1:0] dc;
  logic signed [DC_W-1:0] avg_sh;
  logic signed [DC_W:0]   dc_diff;
  logic signed [DC_W:0]   dc_step;
  logic signed [DC_W-1:0] dc_int;
  logic signed [Y_W-1:0]  y;

  // DC tracker step and the DC-corrected, saturated envelope value.
  always_comb begin
    avg_sh  = $signed({1'b0, avg, {DC_SHIFT{1'b0}}});
    dc_diff = $signed({avg_sh[DC_W-1], avg_sh}) - $signed({dc[DC_W-1], dc});
    dc_step = dc_diff >>> DC_SHIFT;
    dc_int  = dc >>> DC_SHIFT;
    y       = $signed({2'b00, avg}) - $signed({dc_int[IN_W], dc_int[IN_W:0]});
    if (y > SAT_MAX)
      env = SAT_MAX[OUT_W-1:0];
    else if (y < SAT_MIN)
      env = SAT_MIN[OUT_W-1:0];
    else
      env = y[OUT_W-1:0];
  end

  // DC estimate moves once per closed block, using the pre-update value for y.
  always_ff @(posedge clk) begin
    if (rst)
      dc <= '0;
    else if (closing)
      dc <= dc + dc_step[DC_W-1:0];
  end
`else
  logic unused_sum_bits;

  // Plain truncated average; low bits of the sum are intentionally dropped.
  assign env = avg[IN_W-1 -: OUT_W];
  assign unused_sum_bits = ^sum;
`endif

  // Accumulate, close blocks and manage the one-entry output register.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc         <= '0;
      cnt         <= '0;
      out_valid   <= 1'b0;
      out_data    <= '0;
      block_count <= '0;
    end else begin
      if (in_xfer) begin
        if (last_slot) begin
          acc         <= '0;
          cnt         <= '0;
          out_data    <= env;
          block_count <= block_count + 16'd1;
        end else begin
          acc <= sum;
          cnt <= cnt + 1'b1;
        end
      end
      if (closing)
        out_valid <= 1'b1;
      else if (out_xfer)
        out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_am_envelope_decimator.sv
// Directed bench for am_envelope_decimator with DECIM=4, IN_W=16, OUT_W=8.
module tb_am_envelope_decimator;

  localparam int IN_W     = 16;
  localparam int OUT_W    = 8;
  localparam int DECIM    = 4;
  localparam int DC_SHIFT = 2;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [IN_W-1:0]  in_data = '0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [OUT_W-1:0] out_data;
  logic [15:0]      block_count;

  int checks = 0;
  int errors = 0;
  logic [7:0] outq[$];
  longint dc_m = 0;

  am_envelope_decimator #(
    .IN_W(IN_W), .OUT_W(OUT_W), .DECIM(DECIM), .DC_SHIFT(DC_SHIFT)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .block_count(block_count)
  );

  always #5 clk = ~clk;

  // Capture every output handshake that will complete on the next edge.
  always @(negedge clk)
    if (!rst && out_valid && out_ready) outq.push_back(out_data);

  // Expected envelope for one block average; tracks the DC estimate when enabled.
  function automatic logic [7:0] expv(input longint avg);
    longint y;
`ifdef AM_ENV_DC_REMOVE_EN
    y    = avg - (dc_m >>> DC_SHIFT);
    dc_m = dc_m + (((avg <<< DC_SHIFT) - dc_m) >>> DC_SHIFT);
    if (y > 127) y = 127;
    if (y < -128) y = -128;
`else
    y = avg >> 8;
`endif
    return y[7:0];
  endfunction

  task automatic push(input logic [15:0] d);
    int n;
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_data  = d;
    n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (n >= 50) begin
      errors++;
      $display("FAIL push_timeout: in_ready=%b after %0d cycles, required 1", in_ready, n);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      in_valid = 1'b0;
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1; in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    dc_m = 0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== 8'h00 || block_count !== 16'd0) begin
      errors++;
      $display("FAIL reset_state: rdy=%b vld=%b data=%h cnt=%h, required 1 0 00 0000",
               in_ready, out_valid, out_data, block_count);
    end
  endtask

  task automatic test_basic();
    logic [7:0] e;
    out_ready = 1'b1;
    e = expv(64'h1000);
    for (int i = 0; i < 4; i++) push(16'h1000);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL basic_early_valid: out_valid=%b required 0", out_valid);
    end
    idle(1);
    checks++;
    if (out_valid !== 1'b1 || out_data !== e || block_count !== 16'd1) begin
      errors++;
      $display("FAIL basic_out: vld=%b data=%h cnt=%0d, required 1 %h 1", out_valid, out_data, block_count, e);
    end
    idle(1);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL basic_pulse: out_valid=%b required 0", out_valid);
    end
  endtask

  task automatic test_extremes();
    logic [7:0] e;
    e = expv(64'h7FFF);
    push(16'h0000); push(16'hFFFF); push(16'h0000); push(16'hFFFF);
    idle(1);
    checks++;
    if (out_data !== e || block_count !== 16'd2) begin
      errors++; $display("FAIL alt_avg: data=%h cnt=%0d, required %h 2", out_data, block_count, e);
    end
    e = expv(64'hFFFF);
    for (int i = 0; i < 4; i++) push(16'hFFFF);
    idle(1);
    checks++;
    if (out_data !== e || block_count !== 16'd3) begin
      errors++; $display("FAIL full_scale: data=%h cnt=%0d, required %h 3", out_data, block_count, e);
    end
    idle(2);
  endtask

  task automatic test_backpressure();
    logic [7:0] ea, eb;
    outq.delete();
    ea = expv(64'h1000);
    eb = expv(64'h2000);
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) push(16'h1000);
    for (int i = 0; i < 3; i++) push(16'h2000);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== ea) begin
        errors++;
        $display("FAIL bp_stall: rdy=%b vld=%b data=%h, required 0 1 %h", in_ready, out_valid, out_data, ea);
      end
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL bp_release_ready: in_ready=%b required 1", in_ready);
    end
    idle(1);
    checks++;
    if (out_valid !== 1'b1 || out_data !== eb || block_count !== 16'd5) begin
      errors++;
      $display("FAIL bp_second: vld=%b data=%h cnt=%0d, required 1 %h 5", out_valid, out_data, block_count, eb);
    end
    idle(1);
    checks++;
    if (out_valid !== 1'b0 || outq.size() != 2) begin
      errors++; $display("FAIL bp_count: vld=%b outputs=%0d, required 0 2", out_valid, outq.size());
    end else begin
      checks++;
      if (outq[0] !== ea || outq[1] !== eb) begin
        errors++; $display("FAIL bp_order: got %h %h, required %h %h", outq[0], outq[1], ea, eb);
      end
    end
  endtask

  task automatic test_reset_midblock();
    logic [7:0] e;
    push(16'h8000); push(16'h8000);
    idle(1);
    do_reset();
    checks++;
    if (block_count !== 16'd0 || out_valid !== 1'b0) begin
      errors++; $display("FAIL mid_reset: cnt=%0d vld=%b, required 0 0", block_count, out_valid);
    end
    e = expv(64'h0400);
    for (int i = 0; i < 4; i++) push(16'h0400);
    idle(1);
    checks++;
    if (out_data !== e || block_count !== 16'd1) begin
      errors++; $display("FAIL mid_reset_block: data=%h cnt=%0d, required %h 1", out_data, block_count, e);
    end
    idle(2);
  endtask

  task automatic test_sparse();
    logic [7:0] e0, e1;
    outq.delete();
    e0 = expv(64'h2000);
    e1 = expv(64'h2000);
    for (int i = 0; i < 8; i++) begin
      push(16'h2000);
      idle(1);
    end
    idle(3);
    checks++;
    if (outq.size() != 2 || block_count !== 16'd3) begin
      errors++; $display("FAIL sparse_count: outputs=%0d cnt=%0d, required 2 3", outq.size(), block_count);
    end else begin
      checks++;
      if (outq[0] !== e0 || outq[1] !== e1) begin
        errors++; $display("FAIL sparse_data: got %h %h, required %h %h", outq[0], outq[1], e0, e1);
      end
    end
  endtask

  task automatic test_constant_level();
    localparam int NB = 30;
    logic [7:0] e[NB];
    do_reset();
    outq.delete();
    for (int b = 0; b < NB; b++) e[b] = expv(64'h4000);
    for (int b = 0; b < NB; b++)
      for (int i = 0; i < 4; i++) push(16'h4000);
    idle(3);
    checks++;
    if (outq.size() != NB) begin
      errors++; $display("FAIL const_count: outputs=%0d, required %0d", outq.size(), NB);
    end else begin
      for (int b = 0; b < NB; b++) begin
        checks++;
        if (outq[b] !== e[b]) begin
          errors++; $display("FAIL const_block%0d: got %h, required %h", b, outq[b], e[b]);
        end
      end
`ifdef AM_ENV_DC_REMOVE_EN
      checks++;
      if (outq[0] !== 8'h7F) begin
        errors++; $display("FAIL dc_first_sat: got %h, required 7f", outq[0]);
      end
      for (int b = 1; b < NB; b++) begin
        checks++;
        if ($signed(outq[b]) > $signed(outq[b-1])) begin
          errors++; $display("FAIL dc_monotonic%0d: got %h after %h, required non-increasing", b, outq[b], outq[b-1]);
        end
      end
`else
      checks++;
      if (outq[NB-1] !== 8'h40) begin
        errors++; $display("FAIL const_level: got %h, required 40", outq[NB-1]);
      end
`endif
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_extremes();
    test_backpressure();
    test_reset_midblock();
    test_sparse();
    test_constant_level();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
